// File: rtl/cache_write_arbiter.sv
// Round-robin arbiter feeding the cache word-write port. Holds the port until
// the datapath signals ww_done or the watchdog aborts the write.
module cache_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT       = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic                               resp_err,
  output logic                               ww_w_en,
  output logic [ADDRESS_WIDTH-1:0]           ww_word_address,
  output logic [DATA_WIDTH-1:0]              ww_word_data,
  input  logic                               ww_done,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    ~((ADDRESS_WIDTH'(1) << OFF) - ADDRESS_WIDTH'(1));
  localparam logic [GW:0]    NUM_REQ_W = (GW + 1)'(NUM_REQ);
  localparam logic [GW-1:0]  LAST_ID   = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  WD_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                     state_reg, state_next;
  logic [GW-1:0]              rr_ptr_reg;
  logic [GW-1:0]              grant_id_reg;
  logic [ADDRESS_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]      data_reg;
  logic [CW-1:0]              wd_cnt_reg;
  logic [NUM_REQ-1:0]         resp_valid_reg;
  logic                       resp_err_reg;
  logic                       timeout_err_reg;

  logic [ADDRESS_WIDTH-1:0]   addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]      data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Rotating priority search: first valid requester at or above rr_ptr, wrapping.
  logic [GW:0]   cand;
  logic [GW-1:0] pick_idx;
  logic          pick_found;

  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (GW + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  logic wd_last, done_hit, tmo_hit;
  logic [GW-1:0] ptr_after_grant;

  assign wd_last         = (wd_cnt_reg == WD_LAST);
  assign done_hit        = (state_reg == S_WAIT) && ww_done;
  // ww_done in the final watchdog cycle still counts as a clean completion.
  assign tmo_hit         = (state_reg == S_WAIT) && !ww_done && wd_last;
  assign ptr_after_grant = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + GW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (pick_found) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (done_hit || tmo_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    ww_w_en   = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      S_IDLE:  if (pick_found) req_ready[pick_idx] = 1'b1;
      S_ISSUE: begin
        ww_w_en = 1'b1;
        busy    = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      wd_cnt_reg      <= '0;
      resp_valid_reg  <= '0;
      resp_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      resp_valid_reg <= '0;
      resp_err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            grant_id_reg <= pick_idx;
            addr_reg     <= addr_arr[pick_idx] & ALIGN_MASK;
            data_reg     <= data_arr[pick_idx];
          end
        end
        S_ISSUE: wd_cnt_reg <= '0;
        S_WAIT: begin
          if (done_hit || tmo_hit) begin
            resp_valid_reg[grant_id_reg] <= 1'b1;
            resp_err_reg                 <= tmo_hit;
            rr_ptr_reg                   <= ptr_after_grant;
            if (tmo_hit) begin
              timeout_err_reg <= 1'b1;
            end
          end else if (!wd_last) begin
            wd_cnt_reg <= wd_cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid      = resp_valid_reg;
  assign resp_err        = resp_err_reg;
  assign ww_word_address = addr_reg;
  assign ww_word_data    = data_reg;
  assign grant_id        = grant_id_reg;
  assign timeout_err     = timeout_err_reg;

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Randomized bench for cache_write_arbiter: a timeline-based reference model
// predicts every output each cycle; directed scenarios pin the model with literals.
module tb_cache_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam logic [AW-1:0] OFFMASK = AW'(DW / 8 - 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      resp_valid;
  logic              resp_err;
  logic              ww_w_en;
  logic [AW-1:0]     ww_word_address;
  logic [DW-1:0]     ww_word_data;
  logic              ww_done;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  cache_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .ww_w_en(ww_w_en), .ww_word_address(ww_word_address), .ww_word_data(ww_word_data),
    .ww_done(ww_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester-side stimulus state
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
  endtask

  // Reference model: an owner plus the number of cycles since its grant.
  // age 1 = write strobe cycle, age >= 2 = waiting (watchdog count = age - 2).
  bit            m_busy;
  int            m_owner, m_age, m_rr;
  bit            m_sticky;
  logic [N-1:0]  m_resp;
  bit            m_resp_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [N-1:0]  exp_ready = '0, exp_resp = '0;
  bit            exp_wen = 0, exp_busy = 0, exp_err = 0, exp_sticky = 0;
  int            exp_gid = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  logic [N-1:0]  smp_ready, smp_resp;
  logic          smp_wen, smp_busy, smp_err, smp_sticky;
  logic [1:0]    smp_gid;
  logic [AW-1:0] smp_addr;
  logic [DW-1:0] smp_data;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_rr = 0; m_sticky = 0;
    m_resp = '0; m_resp_err = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic compute_expect();
    if (!reset_n) model_reset();
    exp_busy   = m_busy;
    exp_wen    = m_busy && (m_age == 1);
    exp_gid    = m_owner;
    exp_addr   = m_addr;
    exp_data   = m_data;
    exp_resp   = m_resp;
    exp_err    = m_resp_err;
    exp_sticky = m_sticky;
    exp_ready  = '0;
    if (!m_busy && reset_n) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (req_valid[j] && exp_ready == '0) exp_ready[j] = 1'b1;
      end
    end
  endtask

  task automatic advance_model();
    logic [N-1:0] nresp;
    bit nerr;
    nresp = '0;
    nerr  = 0;
    if (!reset_n) begin
      model_reset();
    end else if (!m_busy) begin
      for (int j = 0; j < N; j++) begin
        if (exp_ready[j]) begin
          m_busy = 1; m_owner = j; m_age = 1;
          m_addr = ra[j] & ~OFFMASK;
          m_data = rd[j];
        end
      end
    end else if (m_age >= 2 && (ww_done || (m_age - 2) == TO - 1)) begin
      nresp[m_owner] = 1'b1;
      nerr = !ww_done;
      if (nerr) m_sticky = 1;
      m_rr   = (m_owner + 1) % N;
      m_busy = 0;
      $display("txn req %0d addr %h data %h %s", m_owner, m_addr, m_data, nerr ? "timeout" : "done");
    end else begin
      m_age++;
    end
    if (reset_n) begin
      m_resp     = nresp;
      m_resp_err = nerr;
    end
  endtask

  always @(negedge clk) begin
    smp_ready  = req_ready;  smp_resp   = resp_valid; smp_wen  = ww_w_en;
    smp_busy   = busy;       smp_err    = resp_err;   smp_gid  = grant_id;
    smp_sticky = timeout_err; smp_addr  = ww_word_address; smp_data = ww_word_data;
    if (cmp_en) begin
      chk("req_ready",   64'(req_ready),   64'(exp_ready));
      chk("ww_w_en",     64'(ww_w_en),     64'(exp_wen));
      chk("busy",        64'(busy),        64'(exp_busy));
      chk("resp_valid",  64'(resp_valid),  64'(exp_resp));
      chk("timeout_err", 64'(timeout_err), 64'(exp_sticky));
      if (exp_resp != '0) chk("resp_err", 64'(resp_err), 64'(exp_err));
      if (exp_wen) begin
        chk("ww_word_address", 64'(ww_word_address), 64'(exp_addr));
        chk("ww_word_data",    64'(ww_word_data),    64'(exp_data));
      end
      if (exp_busy || !reset_n) chk("grant_id", 64'(grant_id), 64'(exp_gid));
    end
  end

  // One clock cycle: inputs are already applied at posedge+1.
  task automatic tick();
    compute_expect();
    @(negedge clk);
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    ww_done   = 1'b0;
    pack();
    tick();
  endtask

  // rmode 0: random traffic, 1: every requester always asserting, 2: drop on grant only
  task automatic drive_reqs(input int rmode);
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        if (rmode == 2) begin
          req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          ra[i] = $urandom;
          rd[i] = $urandom;
        end
      end else if (req_valid[i]) begin
        if (rmode == 0 && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end else if (rmode == 1 || (rmode == 0 && $urandom_range(0, 3) == 0)) begin
        req_valid[i] = 1'b1;
        ra[i] = $urandom;
        rd[i] = $urandom;
      end
    end
    pack();
  endtask

  logic [N-1:0] g_seq [16];
  int           g_cnt, g_resp_cnt, g_resp_cyc;
  logic [N-1:0] g_resp_val;
  logic         g_resp_err;

  // done_at: -1 random, -2 always high, -3 never, >= 0 only in that cycle
  task automatic run(input int cycles, input int rmode, input int done_at);
    g_cnt = 0; g_resp_cnt = 0; g_resp_cyc = -1; g_resp_val = '0; g_resp_err = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      drive_reqs(rmode);
      if (done_at == -1)      ww_done = ($urandom_range(0, 3) == 0);
      else if (done_at == -2) ww_done = 1'b1;
      else if (done_at == -3) ww_done = 1'b0;
      else                    ww_done = (c == done_at);
      tick();
      if (smp_ready != '0 && g_cnt < 16) begin
        g_seq[g_cnt] = smp_ready;
        g_cnt++;
      end
      if (smp_resp != '0) begin
        if (g_resp_cnt == 0) begin
          g_resp_cyc = c; g_resp_val = smp_resp; g_resp_err = smp_err;
        end
        g_resp_cnt++;
      end
    end
    ww_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; ww_done = 1'b0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
    pack();
    model_reset();
    @(posedge clk); #1;
    cmp_en = 1'b1;
    tick(); tick();
    chk("reset_busy", 64'(smp_busy), 64'(0));
    chk("reset_gid",  64'(smp_gid),  64'(0));
    reset_n = 1'b1;
    idle();

    // Single request with unaligned address, done one cycle after the strobe
    ra[1] = 32'h0000_1003; rd[1] = 32'hDEAD_BEEF; req_valid = 4'b0010; pack();
    tick(); chk("t1_ready", 64'(smp_ready), 64'(4'b0010));
    req_valid = '0; pack();
    tick();
    chk("t1_wen",  64'(smp_wen),  64'(1));
    chk("t1_addr", 64'(smp_addr), 64'(32'h0000_1000));
    chk("t1_data", 64'(smp_data), 64'(32'hDEAD_BEEF));
    ww_done = 1'b1; tick(); ww_done = 1'b0; tick();
    chk("t1_resp", 64'(smp_resp), 64'(4'b0010));
    chk("t1_err",  64'(smp_err),  64'(0));

    // Pointer sits at 2; only 0 and 1 request, so the search wraps to 0 first
    idle();
    ra[0] = $urandom; rd[0] = $urandom; ra[1] = $urandom; rd[1] = $urandom;
    req_valid = 4'b0011; pack();
    run(12, 2, -2);
    chk("t3_grants", 64'(g_cnt),    64'(2));
    chk("t3_first",  64'(g_seq[0]), 64'(4'b0001));
    chk("t3_second", 64'(g_seq[1]), 64'(4'b0010));

    // Watchdog abort: grant c0, strobe c1, wait from c2, abort response at c10
    idle();
    ra[2] = 32'h2000_0007; rd[2] = $urandom; req_valid = 4'b0100; pack();
    run(14, 2, -3);
    chk("t4_resp_cyc", 64'(g_resp_cyc), 64'(10));
    chk("t4_resp_val", 64'(g_resp_val), 64'(4'b0100));
    chk("t4_resp_err", 64'(g_resp_err), 64'(1));
    chk("t4_sticky",   64'(smp_sticky), 64'(1));

    // ww_done on the last watchdog cycle beats the abort
    idle();
    ra[3] = $urandom; rd[3] = $urandom; req_valid = 4'b1000; pack();
    run(14, 2, 9);
    chk("t5_resp_cyc", 64'(g_resp_cyc), 64'(10));
    chk("t5_resp_val", 64'(g_resp_val), 64'(4'b1000));
    chk("t5_resp_err", 64'(g_resp_err), 64'(0));
    chk("t5_sticky",   64'(smp_sticky), 64'(1));
    run(6, 2, -2);
    chk("t5_stray_resp",  64'(g_resp_cnt), 64'(0));
    chk("t5_stray_grant", 64'(g_cnt),      64'(0));
    chk("t5_stray_busy",  64'(smp_busy),   64'(0));

    // Reset while waiting on requester 3
    idle();
    ra[3] = $urandom; rd[3] = $urandom; req_valid = 4'b1000; pack();
    run(4, 2, -3);
    chk("t6_pre_busy", 64'(smp_busy), 64'(1));
    chk("t6_pre_gid",  64'(smp_gid),  64'(3));
    reset_n = 1'b0; req_valid = '0; pack();
    tick();
    chk("t6_busy",   64'(smp_busy),   64'(0));
    chk("t6_wen",    64'(smp_wen),    64'(0));
    chk("t6_resp",   64'(smp_resp),   64'(0));
    chk("t6_gid",    64'(smp_gid),    64'(0));
    chk("t6_sticky", 64'(smp_sticky), 64'(0));
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin ra[i] = $urandom; rd[i] = $urandom; end
    req_valid = 4'b1111; pack();
    run(30, 1, -2);
    chk("t2_grant_count", 64'(g_cnt >= 6), 64'(1));
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] want;
      want = '0;
      want[k % N] = 1'b1;
      chk("t2_grant_seq", 64'(g_seq[k]), 64'(want));
    end

    // Random traffic with random completions and occasional timeouts
    idle();
    run(600, 0, -1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
